// File: rtl/subcalc_seq.sv
// Sequential 4-bit operation engine: repeats one latched operation COUNT times on an accumulator.
// Optional early stop on an operation event is enabled by defining SUBCALC_SEQ_EVENT_STOP_EN.
module subcalc_seq (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [1:0] KIND,
    input  logic [3:0] DATA_IN,
    input  logic [3:0] COUNT,
    output logic       READY,
    output logic [3:0] RESULT,
    output logic       FLAG,
    output logic [3:0] STEPS,
    output logic       DONE,
    output logic       STOPPED
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_kind;
    logic [3:0] r_acc;
    logic       r_flag;
    logic [3:0] r_steps;
    logic [3:0] r_rem;
    logic [3:0] w_op_acc;
    logic       w_op_flag;
    logic [4:0] w_inc;
    logic       w_last;
    logic       w_stop;

`ifdef SUBCALC_SEQ_EVENT_STOP_EN
    logic       r_stopped;
    logic       w_event;
`endif

    always_comb begin
        w_op_acc  = r_acc;
        w_op_flag = 1'b0;
        w_inc     = {1'b0, r_acc} + 5'd1;
        case (r_kind)
            2'b00: begin
                w_op_acc  = ~r_acc;
                w_op_flag = 1'b1;
            end
            2'b01: begin
                w_op_acc  = {1'b0, r_acc[3:1]};
                w_op_flag = r_acc[0];
            end
            2'b10: begin
                w_op_acc  = w_inc[3:0];
                w_op_flag = w_inc[4];
            end
            default: begin
                w_op_acc  = r_acc - 4'd1;
                w_op_flag = (r_acc != 4'd0);
            end
        endcase
    end

    assign w_last = (r_rem == 4'd1);

`ifdef SUBCALC_SEQ_EVENT_STOP_EN
    // Decrement signals its event through a cleared flag (borrow); the others through a set flag.
    always_comb begin
        case (r_kind)
            2'b00:   w_event = 1'b0;
            2'b11:   w_event = ~w_op_flag;
            default: w_event = w_op_flag;
        endcase
    end
    assign w_stop = w_event & ~w_last;
`else
    assign w_stop = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_next = (COUNT == 4'd0) ? S_FINISH : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last || w_stop) begin
                    w_next = S_FINISH;
                end
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_kind  <= '0;
            r_acc   <= '0;
            r_flag  <= 1'b0;
            r_steps <= '0;
            r_rem   <= '0;
`ifdef SUBCALC_SEQ_EVENT_STOP_EN
            r_stopped <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && START) begin
                r_kind  <= KIND;
                r_acc   <= DATA_IN;
                r_rem   <= COUNT;
                r_flag  <= 1'b0;
                r_steps <= '0;
`ifdef SUBCALC_SEQ_EVENT_STOP_EN
                r_stopped <= 1'b0;
`endif
            end else if (r_state == S_RUN) begin
                r_acc   <= w_op_acc;
                r_flag  <= w_op_flag;
                r_steps <= r_steps + 4'd1;
                r_rem   <= r_rem - 4'd1;
`ifdef SUBCALC_SEQ_EVENT_STOP_EN
                if (w_stop) begin
                    r_stopped <= 1'b1;
                end
`endif
            end
        end
    end

    assign READY  = (r_state == S_IDLE);
    assign DONE   = (r_state == S_FINISH);
    assign RESULT = r_acc;
    assign FLAG   = r_flag;
    assign STEPS  = r_steps;
`ifdef SUBCALC_SEQ_EVENT_STOP_EN
    assign STOPPED = r_stopped;
`else
    assign STOPPED = 1'b0;
`endif

endmodule

// File: tb/tb_subcalc_seq.sv
// Scoreboard bench for subcalc_seq: directed jobs push expectations, a DONE monitor checks them.
module tb_subcalc_seq;

    logic       CLK;
    logic       RESET;
    logic       START;
    logic [1:0] KIND;
    logic [3:0] DATA_IN;
    logic [3:0] COUNT;
    logic       READY;
    logic [3:0] RESULT;
    logic       FLAG;
    logic [3:0] STEPS;
    logic       DONE;
    logic       STOPPED;

    subcalc_seq dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .START   (START),
        .KIND    (KIND),
        .DATA_IN (DATA_IN),
        .COUNT   (COUNT),
        .READY   (READY),
        .RESULT  (RESULT),
        .FLAG    (FLAG),
        .STEPS   (STEPS),
        .DONE    (DONE),
        .STOPPED (STOPPED)
    );

    typedef struct {
        string       name;
        logic [3:0]  result;
        logic        flag;
        logic [3:0]  steps;
        logic        stopped;
        int unsigned done_cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_fail;
    bit          mon_en;

`ifdef SUBCALC_SEQ_EVENT_STOP_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every DONE cycle must match the oldest outstanding job.
    always @(negedge CLK) begin
        if (mon_en && DONE === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, ".result"},  RESULT,  e.result);
                check({e.name, ".flag"},    FLAG,    e.flag);
                check({e.name, ".steps"},   STEPS,   e.steps);
                check({e.name, ".stopped"}, STOPPED, e.stopped);
                check({e.name, ".done_cyc"}, cyc,    e.done_cyc);
            end
        end
    end

    task automatic run_job(input string name, input logic [1:0] k, input logic [3:0] d,
                           input logic [3:0] c, input logic [3:0] res, input logic fl,
                           input logic [3:0] st, input logic stp, input int unsigned len,
                           input bit noise);
        exp_t e;
        int unsigned guard;
        @(negedge CLK);
        START   = 1'b1;
        KIND    = k;
        DATA_IN = d;
        COUNT   = c;
        @(posedge CLK);
        #1;
        e.name = name; e.result = res; e.flag = fl; e.steps = st; e.stopped = stp;
        e.done_cyc = cyc + len;
        sb.push_back(e);
        START   = 1'b0;
        if (noise) begin
            @(negedge CLK);
            check({name, ".busy"}, READY, 0);
            START   = 1'b1;
            KIND    = 2'b00;
            DATA_IN = 4'hF;
            COUNT   = 4'h1;
            @(negedge CLK);
            @(negedge CLK);
            START = 1'b0;
        end
        guard = 0;
        while ((sb.size() != 0 || READY !== 1'b1) && guard < 40) begin
            @(negedge CLK);
            guard++;
        end
        check({name, ".complete"}, (guard < 40) ? 1 : 0, 1);
        @(negedge CLK);
        check({name, ".hold_result"}, RESULT, res);
        check({name, ".ready"}, READY, 1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        cyc      = 0;
        RESET    = 1'b1;
        START    = 1'b0;
        KIND     = '0;
        DATA_IN  = '0;
        COUNT    = '0;
        @(negedge CLK);
        RESET = 1'b0;
        check("rst.ready",   READY,   1);
        check("rst.done",    DONE,    0);
        check("rst.result",  RESULT,  0);
        check("rst.flag",    FLAG,    0);
        check("rst.steps",   STEPS,   0);
        check("rst.stopped", STOPPED, 0);
        mon_en = 1'b1;

        run_job("inc3x5", 2'b10, 4'h3, 4'd5, 4'h8, 1'b0, 4'd5, 1'b0, 5, 1'b1);
        if (STOP_EN)
            run_job("dec1x3", 2'b11, 4'h1, 4'd3, 4'hF, 1'b0, 4'd2, 1'b1, 2, 1'b0);
        else
            run_job("dec1x3", 2'b11, 4'h1, 4'd3, 4'hE, 1'b1, 4'd3, 1'b0, 3, 1'b0);
        run_job("inv5x0", 2'b00, 4'h5, 4'd0, 4'h5, 1'b0, 4'd0, 1'b0, 0, 1'b0);
        run_job("shrAx2", 2'b01, 4'hA, 4'd2, 4'h2, 1'b1, 4'd2, 1'b0, 2, 1'b0);
        run_job("inv6x3", 2'b00, 4'h6, 4'd3, 4'h9, 1'b1, 4'd3, 1'b0, 3, 1'b0);
        if (STOP_EN)
            run_job("incEx3", 2'b10, 4'hE, 4'd3, 4'h0, 1'b1, 4'd2, 1'b1, 2, 1'b0);
        else
            run_job("incEx3", 2'b10, 4'hE, 4'd3, 4'h1, 1'b0, 4'd3, 1'b0, 3, 1'b0);
        run_job("dec0x1", 2'b11, 4'h0, 4'd1, 4'hF, 1'b0, 4'd1, 1'b0, 1, 1'b0);

        // Reset lands on E3 of an 8-op job; the monitor flags any DONE.
        @(negedge CLK);
        START = 1'b1; KIND = 2'b11; DATA_IN = 4'h9; COUNT = 4'd8;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        START = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        START = 1'b0;
        check("mid_rst.ready",   READY,   1);
        check("mid_rst.done",    DONE,    0);
        check("mid_rst.result",  RESULT,  0);
        check("mid_rst.flag",    FLAG,    0);
        check("mid_rst.steps",   STEPS,   0);
        check("mid_rst.stopped", STOPPED, 0);
        repeat (12) @(negedge CLK);
        check("mid_rst.idle", READY, 1);
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
